// File: rtl/tt_extractor.sv
// Sweeps all 128 minterms of a 7-input function-under-test and rebuilds its truth table.
// Also produces the on-set size and a match flag against a reference signature.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SWEEP  | driving minterms and sampling fut_out
// FINISH | one cycle to compare the completed table
// DONE   | results held, start accepted again
module tt_extractor #(
  parameter logic [127:0] EXPECTED_TT = 128'hfeeaeeeafce8ec80fec8e8c0a888a880,
  parameter int           FUT_LAT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [6:0]   fut_x,
  input  logic         fut_out,
  output logic         busy,
  output logic         done,
  output logic [127:0] tt,
  output logic [7:0]   ones_count,
  output logic         match
);

  localparam int WW = (FUT_LAT > 0) ? $clog2(FUT_LAT + 1) : 1;
  localparam logic [WW-1:0] WLOAD = WW'(FUT_LAT);

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [6:0]    idx;
  logic [WW-1:0] wcnt;
  logic          sample;
  logic          last;
  logic          busy_nxt;
  logic          done_nxt;

  // The settle timer counts down from FUT_LAT; fut_out is valid when it reaches zero.
  assign sample = (state == SWEEP) && (wcnt == '0);
  assign last   = sample && (idx == 7'd127);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (last)  state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE:    if (start) state_nxt = SWEEP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == SWEEP);
    done_nxt = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fut_x      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= '0;
      ones_count <= '0;
      match      <= 1'b0;
      idx        <= '0;
      wcnt       <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            fut_x      <= '0;
            wcnt       <= WLOAD;
            tt         <= '0;
            ones_count <= '0;
            match      <= 1'b0;
          end
        end
        SWEEP: begin
          if (sample) begin
            tt[idx]    <= fut_out;
            ones_count <= ones_count + {7'd0, fut_out};
            if (last) begin
              fut_x <= '0;
            end else begin
              idx   <= idx + 7'd1;
              fut_x <= idx + 7'd1;
              wcnt  <= WLOAD;
            end
          end else begin
            wcnt <= wcnt - {{(WW-1){1'b0}}, 1'b1};
          end
        end
        FINISH: begin
          match <= (tt == EXPECTED_TT);
          fut_x <= '0;
        end
        default: begin
          fut_x <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_extractor.sv
// Self-checking bench for tt_extractor: directed and random FUT tables against a
// truth-table model, plus latency, abort and back-to-back sweep behaviour.
module tb_tt_extractor;

  localparam logic [127:0] EXP = 128'hfeeaeeeafce8ec80fec8e8c0a888a880;
  localparam int M_TAB = 0, M_ZERO = 1, M_ONE = 2, M_X0 = 3, M_X6 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [6:0]   fx_a, fx_b, fx_c;
  logic         fut_a, fut_b, fut_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic [127:0] tt_a, tt_b, tt_c;
  logic [7:0]   ones_a, ones_b, ones_c;
  logic         match_a, match_b, match_c;

  int           mode = M_ZERO;
  logic [127:0] tab = '0;
  logic [127:0] sig = EXP;
  logic         pb1 = 1'b0, pb2 = 1'b0, pc1 = 1'b0, pc2 = 1'b0;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int t0 = 0;
  int bcnt [3];
  logic bclr = 1'b0;

  always #5 clk = ~clk;

  function automatic logic fn(input int m, input logic [127:0] t, input logic [6:0] x);
    case (m)
      M_TAB:  fn = t[x];
      M_ONE:  fn = 1'b1;
      M_X0:   fn = x[0];
      M_X6:   fn = x[6];
      default: fn = 1'b0;
    endcase
  endfunction

  assign fut_a = fn(mode, tab, fx_a);
  assign fut_b = pb2;
  assign fut_c = pc2;

  // Two-stage registered FUT copies for the latency instances.
  always @(posedge clk) begin
    pb1 <= sig[fx_b];
    pb2 <= pb1;
    pc1 <= sig[fx_c];
    pc2 <= pc1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bclr) begin
      for (int d = 0; d < 3; d++) bcnt[d] = 0;
    end else begin
      if (busy_a) bcnt[0] = bcnt[0] + 1;
      if (busy_b) bcnt[1] = bcnt[1] + 1;
      if (busy_c) bcnt[2] = bcnt[2] + 1;
    end
  end

  tt_extractor #(.EXPECTED_TT(EXP), .FUT_LAT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .fut_x(fx_a), .fut_out(fut_a),
    .busy(busy_a), .done(done_a), .tt(tt_a), .ones_count(ones_a), .match(match_a));

  tt_extractor #(.EXPECTED_TT(EXP), .FUT_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .fut_x(fx_b), .fut_out(fut_b),
    .busy(busy_b), .done(done_b), .tt(tt_b), .ones_count(ones_b), .match(match_b));

  tt_extractor #(.EXPECTED_TT(EXP), .FUT_LAT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_b), .fut_x(fx_c), .fut_out(fut_c),
    .busy(busy_c), .done(done_c), .tt(tt_c), .ones_count(ones_c), .match(match_c));

  // Reference model: expected table straight from the FUT's definition.
  function automatic logic [127:0] model_tt(input int m, input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    case (m)
      M_TAB: r = t;
      M_ONE: r = '1;
      M_X0:  for (int i = 0; i < 128; i++) r[i] = ((i % 2) == 1);
      M_X6:  for (int i = 0; i < 128; i++) r[i] = (i >= 64);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int popcnt(input logic [127:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 128; i++) s += int'(v[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input int sel);
    bclr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bclr = 1'b0;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int d, input int bound, output int el);
    logic dn;
    dn = (d == 0) ? done_a : (d == 1) ? done_b : done_c;
    while (!dn && (cyc - t0) < bound) begin
      @(negedge clk);
      dn = (d == 0) ? done_a : (d == 1) ? done_b : done_c;
    end
    el = cyc - t0;
  endtask

  task automatic run_a(input string tag, input int m, input logic [127:0] t);
    int el;
    logic [127:0] e;
    mode = m;
    tab = t;
    e = model_tt(m, t);
    do_start(0);
    wait_done(0, 1000, el);
    chk({tag, "_latency"}, el, 129);
    chk({tag, "_busy_cycles"}, bcnt[0], 128);
    chk({tag, "_tt"}, tt_a, e);
    chk({tag, "_ones"}, ones_a, popcnt(e));
    chk({tag, "_match"}, match_a, (e == EXP));
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_a, 0);
    chk({tag, "_fut_x_idle"}, fx_a, 0);
    chk({tag, "_tt_hold"}, tt_a, e);
  endtask

  initial begin
    int el;
    int k;
    logic saw;
    logic [127:0] e;

    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tt", tt_a, 0);
    chk("rst_ones", ones_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_fut_x", fx_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_a("maj", M_TAB, EXP);
    chk("maj_ones_64", ones_a, 64);
    run_a("zero", M_ZERO, '0);
    run_a("one", M_ONE, '0);
    run_a("x0", M_X0, '0);
    chk("x0_pattern", tt_a, {32{4'ha}});
    run_a("x6", M_X6, '0);
    for (int r = 0; r < 4; r++) begin
      run_a("rand", M_TAB, {$urandom, $urandom, $urandom, $urandom});
    end

    // Registered FUT: latency-matched instance b, unmatched instance c.
    do_start(1);
    repeat (10) @(negedge clk);
    chk("lat2_fut_x_cadence", fx_b, 3);
    wait_done(2, 1000, el);
    chk("lat0_pipe_latency", el, 129);
    chk("lat0_pipe_match", match_c, 0);
    wait_done(1, 1000, el);
    chk("lat2_latency", el, 385);
    chk("lat2_busy_cycles", bcnt[1], 384);
    chk("lat2_tt", tt_b, EXP);
    chk("lat2_ones", ones_b, popcnt(EXP));
    chk("lat2_match", match_b, 1);

    // start re-pulsed mid-sweep is ignored.
    mode = M_TAB;
    tab = EXP;
    do_start(0);
    k = 0;
    while (fx_a != 7'd40 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_idx40", fx_a, 40);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 1000, el);
    chk("restart_ignored_latency", el, 129);
    chk("restart_ignored_tt", tt_a, EXP);

    // Reset mid-sweep aborts with no done pulse.
    do_start(0);
    k = 0;
    while (fx_a != 7'd70 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_idx70", fx_a, 70);
    rst_n = 1'b0;
    #1;
    chk("abort_fut_x", fx_a, 0);
    chk("abort_tt", tt_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_ones", ones_a, 0);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw |= done_a;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw |= done_a;
    end
    chk("abort_no_done", saw, 0);
    run_a("after_abort", M_X0, '0);

    // start held high: back-to-back sweeps through DONE.
    mode = M_TAB;
    tab = EXP;
    e = model_tt(M_TAB, EXP);
    start_a = 1'b1;
    @(negedge clk);
    t0 = cyc;
    for (int n = 0; n < 3; n++) begin
      wait_done(0, 1000, el);
      chk("b2b_latency", el, 129 + 130 * n);
      chk("b2b_tt", tt_a, e);
      chk("b2b_match", match_a, 1);
      @(negedge clk);
      chk("b2b_done_pulse", done_a, 0);
    end
    start_a = 1'b0;
    t0 = cyc;
    wait_done(0, 300, el);
    chk("b2b_final_done", done_a, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
